// File: rtl/dmem_byte_ctrl.sv
// Data-memory byte-lane controller: lane-aligned stores, extended registered loads,
// load stall and misaligned-access rejection over an internal word-addressed RAM.
module dmem_byte_ctrl #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  byte_control_i,
  input  logic        ld_signed_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        stall_o,
  output logic        misalign_o
);

  localparam int unsigned DW    = 32;
  localparam int unsigned LANES = DW / 8;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_RESP} state_e;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  state_e           state_q, state_d;
  size_e            size_q, size_d;
  logic [1:0]       off_q, off_d;
  logic             sign_q, sign_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             done_q, done_d;
  logic             misalign_q, misalign_d;

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DW-1:0]    rd_word_q;

  size_e            size_c;
  logic             misalign_c;
  logic             accept_c;
  logic             wr_en_c;
  logic             rd_en_c;
  logic [LANES-1:0] be_c;
  logic [DW-1:0]    wlane_c;
  logic [AW-1:0]    word_idx_c;
  logic [7:0]       sel_byte_c;
  logic [15:0]      sel_half_c;
  logic [DW-1:0]    ext_c;
  logic             unused_addr;

  // Upper address bits alias; only the word index and lane offset matter.
  assign word_idx_c  = addr_i[AW+1:2];
  assign unused_addr = ^addr_i[31:AW+2];

  // Size decode and alignment check; unknown codes behave as word.
  always_comb begin
    size_c = SZ_WORD;
    case (byte_control_i)
      4'b0001: size_c = SZ_BYTE;
      4'b0011: size_c = SZ_HALF;
      default: size_c = SZ_WORD;
    endcase
  end

  assign misalign_c = ((size_c == SZ_HALF) && addr_i[0]) ||
                      ((size_c == SZ_WORD) && (addr_i[1:0] != 2'b00));
  assign accept_c   = (state_q == S_IDLE) && req_i;
  assign wr_en_c    = accept_c && we_i && !misalign_c;
  assign rd_en_c    = accept_c && !we_i && !misalign_c;

  // Byte enables and store data replicated so each enabled lane sees its payload.
  always_comb begin
    be_c    = 4'b1111;
    wlane_c = wdata_i;
    case (size_c)
      SZ_BYTE: begin
        be_c    = 4'(4'b0001 << addr_i[1:0]);
        wlane_c = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        be_c    = addr_i[1] ? 4'b1100 : 4'b0011;
        wlane_c = {2{wdata_i[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wlane_c = wdata_i;
      end
    endcase
  end

  // Write-first is implicit: a store one cycle ahead lands before the load's read edge.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      for (int l = 0; l < LANES; l++) begin
        if (be_c[l]) mem_q[word_idx_c][8*l +: 8] <= wlane_c[8*l +: 8];
      end
    end
    if (rd_en_c) rd_word_q <= mem_q[word_idx_c];
  end

  // Lane selection and extension of the registered RAM word.
  assign sel_byte_c = 8'(rd_word_q >> {off_q, 3'b000});
  assign sel_half_c = off_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];

  always_comb begin
    ext_c = rd_word_q;
    case (size_q)
      SZ_BYTE: ext_c = {{24{sign_q & sel_byte_c[7]}}, sel_byte_c};
      SZ_HALF: ext_c = {{16{sign_q & sel_half_c[15]}}, sel_half_c};
      default: ext_c = rd_word_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    off_d      = off_q;
    sign_d     = sign_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    misalign_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (misalign_c) begin
            misalign_d = 1'b1;
            done_d     = 1'b1;
          end else if (we_i) begin
            done_d = 1'b1;
          end else begin
            size_d  = size_c;
            off_d   = addr_i[1:0];
            sign_d  = ld_signed_i;
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        rdata_d = ext_c;
        done_d  = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      size_q     <= SZ_WORD;
      off_q      <= 2'b00;
      sign_q     <= 1'b0;
      rdata_q    <= '0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      off_q      <= off_d;
      sign_q     <= sign_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      misalign_q <= misalign_d;
    end
  end

  // Stall rises in the issuing cycle so the pipeline freezes before READ.
  assign stall_o    = rd_en_c || (state_q == S_READ);
  assign rdata_o    = rdata_q;
  assign done_o     = done_q;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_dmem_byte_ctrl.sv
// Bench for dmem_byte_ctrl: directed scenarios then random accesses against a
// byte-array memory model with arithmetic extension.
module tb_dmem_byte_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  bc;
  logic        lds;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        stall;
  logic        misalign;

  int          nvec = 0;
  int          nerr = 0;
  logic [7:0]  mem_m [1024];
  logic [31:0] exp_rdata = '0;

  dmem_byte_ctrl #(.DEPTH(256), .AW(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         (req),
    .we_i          (we),
    .addr_i        (addr),
    .byte_control_i(bc),
    .ld_signed_i   (lds),
    .wdata_i       (wdata),
    .rdata_o       (rdata),
    .done_o        (done),
    .stall_o       (stall),
    .misalign_o    (misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [3:0] code);
    if (code == 4'b0001) return 1;
    if (code == 4'b0011) return 2;
    return 4;
  endfunction

  // One complete access: drive, check every cycle until completion, update the model.
  task automatic do_access(input logic w, input logic [31:0] a, input logic [3:0] code,
                           input logic s, input logic [31:0] wd);
    int     sz;
    int     bi;
    bit     mis;
    longint v;
    sz  = size_of(code);
    bi  = int'(a % 1024);
    mis = (int'(a[1:0]) % sz) != 0;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; bc = code; lds = s; wdata = wd;
    #1;
    check("stall_issue", 32'(stall), 32'(!w && !mis));
    @(posedge clk);
    #1;
    req = 1'b0;
    addr = $urandom(); wdata = $urandom(); we = $urandom_range(0, 1);
    if (mis) begin
      check("mis_flag", 32'(misalign), 32'd1);
      check("mis_done", 32'(done), 32'd1);
      check("mis_stall", 32'(stall), 32'd0);
      check("mis_rdata_hold", rdata, exp_rdata);
      @(posedge clk);
      #1;
      check("mis_pulse_end", 32'({misalign, done}), 32'd0);
    end else if (w) begin
      for (int k = 0; k < sz; k++) mem_m[bi + k] = 8'((wd >> (8 * k)) & 32'hFF);
      check("st_done", 32'(done), 32'd1);
      check("st_nomis", 32'(misalign), 32'd0);
      check("st_rdata_hold", rdata, exp_rdata);
    end else begin
      check("ld_read_stall", 32'({stall, done}), 32'b10);
      req = 1'b1;
      @(posedge clk);
      #1;
      req = 1'b0;
      v = 0;
      for (int k = 0; k < sz; k++) v += longint'(mem_m[bi + k]) << (8 * k);
      if (s && v >= (longint'(1) << (8 * sz - 1))) v -= longint'(1) << (8 * sz);
      exp_rdata = 32'(v);
      check("ld_done", 32'(done), 32'd1);
      check("ld_resp_stall", 32'(stall), 32'd0);
      check("ld_rdata", rdata, exp_rdata);
      @(posedge clk);
      #1;
      check("ld_done_end", 32'(done), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] r;
    logic [3:0]  code;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; bc = 4'b1111; lds = 1'b0; wdata = '0;
    #12;
    check("rst_outputs", {rdata[28:0], done, stall, misalign}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed scenarios.
    do_access(1'b1, 32'h10, 4'b1111, 1'b0, 32'hDEADBEEF);
    do_access(1'b0, 32'h10, 4'b1111, 1'b0, 32'h0);
    check("word_load", rdata, 32'hDEADBEEF);
    do_access(1'b1, 32'h13, 4'b0001, 1'b0, 32'h00000080);
    do_access(1'b0, 32'h10, 4'b1111, 1'b0, 32'h0);
    check("byte_lane_write", rdata, 32'h80ADBEEF);
    do_access(1'b0, 32'h13, 4'b0001, 1'b1, 32'h0);
    check("byte_signed", rdata, 32'hFFFFFF80);
    do_access(1'b0, 32'h13, 4'b0001, 1'b0, 32'h0);
    check("byte_unsigned", rdata, 32'h00000080);
    do_access(1'b1, 32'h16, 4'b0011, 1'b0, 32'h0000BEEF);
    do_access(1'b0, 32'h16, 4'b0011, 1'b1, 32'h0);
    check("half_signed", rdata, 32'hFFFFBEEF);
    do_access(1'b1, 32'h11, 4'b0011, 1'b0, 32'h12345678);
    do_access(1'b1, 32'h12, 4'b1111, 1'b0, 32'h12345678);
    do_access(1'b0, 32'h12, 4'b0110, 1'b0, 32'h0);
    do_access(1'b0, 32'h10, 4'b1111, 1'b0, 32'h0);
    check("mis_ram_unchanged", rdata, 32'h80ADBEEF);
    do_access(1'b0, 32'h1410, 4'b1111, 1'b0, 32'h0);
    check("addr_alias", rdata, 32'h80ADBEEF);

    // Reset while the load sits in READ.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h10; bc = 4'b1111; lds = 1'b0;
    @(posedge clk);
    #1;
    req = 1'b0;
    check("rst_mid_pre_stall", 32'(stall), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_stall", 32'(stall), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_rdata", rdata, 32'd0);
    exp_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    do_access(1'b0, 32'h16, 4'b0011, 1'b0, 32'h0);
    check("post_rst_load", rdata, 32'h0000BEEF);

    // Seed the random window with known words, then random mixed traffic.
    for (int i = 0; i < 16; i++) do_access(1'b1, 32'(4 * i), 4'b1111, 1'b0, $urandom());
    for (int n = 0; n < 400; n++) begin
      r = $urandom();
      case ($urandom_range(0, 3))
        0: code = 4'b0001;
        1: code = 4'b0011;
        2: code = 4'b1111;
        default: code = 4'($urandom_range(0, 15));
      endcase
      do_access(1'($urandom_range(0, 1)), r & 32'hFFFF_FC3F, code,
                1'($urandom_range(0, 1)), $urandom());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/dmem_byte_ctrl.md
Name: dmem_byte_ctrl

Overview:
- Data-memory access controller sitting directly downstream of the store-data byte masker in the MEM stage.
- Accepts a masked store word, or a load request, with a 4-bit byte-lane control code and a byte address; owns an internal word-addressed RAM.
- Performs lane-aligned byte-enable writes; returns sign- or zero-extended load data after a registered read.
- Raises a pipeline stall while a load is in flight and flags misaligned accesses without touching memory.

Parameters:
- DEPTH, 256, number of 32-bit words in the RAM; power of two.
- AW, 8, word-address width, equal to log2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  access request, sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- addr  in  32  byte address; bits [AW+1:2] select the word, bits [1:0] select the lane.
- ByteControl  in  4  size code: 4'b1111 word, 4'b0011 half, 4'b0001 byte; any other code is treated as word.
- ld_signed  in  1  load extension: 1 = sign-extend, 0 = zero-extend.
- wdata  in  32  store data, already masked so the payload is in the low bits.
- rdata  out  32  extended load result, valid when done=1 for a load.
- done  out  1  one-cycle pulse marking completion of an access.
- stall  out  1  high while a load is pending; holds the pipeline.
- misalign  out  1  one-cycle pulse marking a rejected misaligned access.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - rdata=0, done=0, stall=0, misalign=0.
  - RAM contents are not reset.
- Misalignment rule:
  - Half access requires addr[0]=0.
  - Word access requires addr[1:0]=0.
  - Byte access is always aligned.
- State IDLE:
  - req=0: remain in IDLE.
  - req=1 and misaligned: misalign=1 and done=1 on the next cycle; no RAM write; rdata unchanged; stay in IDLE.
  - req=1, we=1, aligned: RAM lanes are written at the same clock edge.
    - Byte: lane addr[1:0] receives wdata[7:0].
    - Half: lanes {addr[1],0} and {addr[1],1} receive wdata[15:0].
    - Word: all four lanes receive wdata.
    - Other lanes are untouched. done=1 next cycle; stay in IDLE. Store latency is 1 cycle.
  - req=1, we=0, aligned: latch addr[1:0], size and ld_signed; issue the synchronous RAM read; stall=1 asserted combinationally that same cycle; go to READ.
- State READ:
  - RAM output is now valid; select the lane(s) by the latched offset.
  - Extend the selected data per the latched ld_signed:
    - byte uses bit 7 of the selected lane;
    - half uses bit 15 of the selected halfword;
    - word passes through.
  - Register the result into rdata.
  - stall=1 for the whole cycle; go to RESP.
- State RESP:
  - done=1 and stall=0; rdata is valid.
  - req is ignored in this cycle; return to IDLE. Load latency is 2 cycles from request to done.
- Output holding:
  - rdata holds its value until the next load completes.
  - Stores and misaligned accesses never modify rdata.
- Inputs during busy: req, we, addr and wdata are ignored in READ and RESP; the pipeline is frozen by stall.
- Address wrap: word index uses addr[AW+1:2] only; upper bits are ignored, so addresses alias modulo 4*DEPTH bytes.
- Store followed by load to the same word in the next cycle: the load returns the newly written data (write happens before the read).
- Reset mid-load (asserted in READ or RESP): return to IDLE immediately; stall and done drop asynchronously; the load result is discarded.

Test Plan:
- Word store/load: store 32'hDEADBEEF at addr 0x10, ByteControl=1111, then load word from 0x10 → done one cycle after the store; load gives stall for 2 cycles, then done with rdata=32'hDEADBEEF.
- Byte lane write: after the word above, store byte 8'h80 (wdata=32'h00000080) at 0x13 → word load from 0x10 returns 32'h80ADBEEF.
- Byte load extension: load byte from 0x13 with ld_signed=1 → rdata=32'hFFFFFF80; with ld_signed=0 → 32'h00000080.
- Halfword: store half 16'hBEEF at 0x16, then signed half load from 0x16 → rdata=32'hFFFFBEEF.
- Misaligned: half access at 0x11, word access at 0x12 → misalign=1 and done=1 for one cycle each; stall stays 0; RAM is unchanged, confirmed by reloading the word.
- Reset mid-load: assert rst_n=0 in READ → stall=0, done=0, rdata=0 immediately; after release, a new load completes normally in 2 cycles.
